// File: rtl/seg14_scroll_scanner.sv
// rtl/seg14_scroll_scanner.sv - multiplexed 14-segment display scanner with static or scrolling message buffer
module seg14_scroll_scanner #(
  parameter int DIGITS     = 12,
  parameter int MSG_DEPTH  = 32,
  parameter int SCAN_DIV   = 1,
  parameter int SCROLL_DIV = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [13:0]                  wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  input  logic                         blank,
  output logic [DIGITS-1:0]            sel,
  output logic [13:0]                  segm,
  output logic                         frame_done
);
  localparam int AW        = $clog2(MSG_DEPTH);
  localparam int IW        = $clog2(DIGITS);
  localparam int PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW        = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SW        = AW + IW + 1;
  localparam int RED_STEPS = 2 * MSG_DEPTH + DIGITS;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [13:0]   mem [MSG_DEPTH];
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [PW-1:0] presc;
  logic [FW-1:0] frame_cnt;
  logic [AW-1:0] offset;
  logic [AW:0]   len_eff;
  logic          tick;
  logic          wrap;
  logic          scroll_step;
  logic [SW-1:0] pos;
  logic [13:0]   glyph;

  always_comb begin
    len_eff     = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
    tick        = (presc == PW'(SCAN_DIV - 1));
    wrap        = (idx == LAST);
    idx_next    = wrap ? '0 : idx + IW'(1);
    scroll_step = tick && wrap && (frame_cnt == FW'(SCROLL_DIV - 1));
  end

  // (offset + digit) mod L by bounded compare-and-subtract; enough steps even for L == 1
  always_comb begin
    pos = SW'(scroll_en ? offset : '0) + SW'(idx_next);
    for (int i = 0; i < RED_STEPS; i++) begin
      if (len_eff != '0 && pos >= SW'(len_eff)) begin
        pos = pos - SW'(len_eff);
      end
    end
    glyph = '0;
    if (len_eff != '0) begin
      if (scroll_en) begin
        glyph = mem[pos[AW-1:0]];
      end else if (SW'(idx_next) < SW'(len_eff)) begin
        glyph = mem[AW'(idx_next)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      segm       <= '0;
      frame_done <= 1'b0;
      idx        <= LAST;
      presc      <= '0;
      frame_cnt  <= '0;
      offset     <= '0;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_DEPTH))) begin
        mem[wr_addr] <= wr_data;
      end
      frame_done <= tick && (idx_next == LAST);
      if (tick) begin
        presc <= '0;
        idx   <= idx_next;
      end else begin
        presc <= presc + PW'(1);
      end
      // blanking only gates the outputs; scanning and scrolling keep running underneath
      if (blank) begin
        sel  <= '0;
        segm <= '0;
      end else if (tick) begin
        sel  <= DIGITS'(1) << idx_next;
        segm <= glyph;
      end
      if (tick && wrap) begin
        frame_cnt <= scroll_step ? '0 : frame_cnt + FW'(1);
      end
      if (!scroll_en || ({1'b0, offset} >= len_eff)) begin
        offset <= '0;
      end else if (scroll_step) begin
        offset <= (({1'b0, offset} + (AW+1)'(1)) >= len_eff) ? '0 : offset + AW'(1);
      end
    end
  end
endmodule
